// File: rtl/line_fill_writer_if.sv
// Pixel stream (valid/ready/last) and line-buffer write port used by line_fill_writer.
// The writer attaches as slave; the upstream source and buffer side attach as master.
interface line_fill_writer_if;
    logic        s_valid;
    logic [23:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic [9:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_en;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wr_addr, wr_data, wr_en
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/line_fill_writer.sv
// Line buffer write-side controller: fills one line per request and flags short/long lines.
// Define LINE_FILL_PAD_EN to pad short lines with PAD_COLOR up to H_ACTIVE entries.
module line_fill_writer #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter logic [23:0] PAD_COLOR = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_line_req,
    line_fill_writer_if.slave bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_short,
    output logic              o_err_long
);
    localparam logic [9:0] LAST_ADDR = 10'(H_ACTIVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
`ifdef LINE_FILL_PAD_EN
        ST_PAD,
`endif
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_cnt;
    logic [9:0]  w_cnt_next;
    logic        r_wr_en;
    logic        w_wr_en_next;
    logic [9:0]  r_wr_addr;
    logic [9:0]  w_wr_addr_next;
    logic [23:0] r_wr_data;
    logic [23:0] w_wr_data_next;
    logic        r_err_short;
    logic        w_err_short_next;
    logic        r_err_long;
    logic        w_err_long_next;
    logic        w_s_ready;
    logic        w_accept;

`ifndef LINE_FILL_PAD_EN
    logic        w_unused_pad;
    assign w_unused_pad = ^PAD_COLOR;
`endif

    // Ready decodes from state only, so there is no combinational path from s_valid.
    assign w_s_ready = (r_state == ST_FILL) || (r_state == ST_DRAIN);
    assign w_accept  = bus.s_valid && w_s_ready;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_wr_en_next     = 1'b0;
        w_wr_addr_next   = r_wr_addr;
        w_wr_data_next   = r_wr_data;
        w_err_short_next = r_err_short;
        w_err_long_next  = r_err_long;
        case (r_state)
            ST_IDLE: begin
                if (i_line_req) begin
                    w_cnt_next       = '0;
                    w_err_short_next = 1'b0;
                    w_err_long_next  = 1'b0;
                    w_state_next     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = r_cnt;
                    w_wr_data_next = bus.s_data;
                    w_cnt_next     = r_cnt + 10'd1;
                    if (r_cnt == LAST_ADDR) begin
                        if (bus.s_last) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_err_long_next = 1'b1;
                            w_state_next    = ST_DRAIN;
                        end
                    end else if (bus.s_last) begin
                        w_err_short_next = 1'b1;
`ifdef LINE_FILL_PAD_EN
                        w_state_next     = ST_PAD;
`else
                        w_state_next     = ST_DONE;
`endif
                    end
                end
            end
            ST_DRAIN: begin
                if (w_accept && bus.s_last) begin
                    w_state_next = ST_DONE;
                end
            end
`ifdef LINE_FILL_PAD_EN
            ST_PAD: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = r_cnt;
                w_wr_data_next = PAD_COLOR;
                w_cnt_next     = r_cnt + 10'd1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_wr_en     <= w_wr_en_next;
            r_wr_addr   <= w_wr_addr_next;
            r_wr_data   <= w_wr_data_next;
            r_err_short <= w_err_short_next;
            r_err_long  <= w_err_long_next;
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_err_short  = r_err_short;
    assign o_err_long   = r_err_long;
endmodule

// File: tb/tb_line_fill_writer.sv
// Directed bench for line_fill_writer with H_ACTIVE=8; expected writes are queued at
// drive time and popped by a write monitor. Build with LINE_FILL_PAD_EN to cover padding.
module tb_line_fill_writer;
    localparam int unsigned H = 8;
`ifdef LINE_FILL_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef struct {
        logic [9:0]  addr;
        logic [23:0] data;
        logic        dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic line_req;
    logic busy;
    logic done;
    logic err_short;
    logic err_long;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    line_fill_writer_if bus ();

    line_fill_writer #(
        .H_ACTIVE  (H),
        .PAD_COLOR (24'h123456)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_line_req  (line_req),
        .bus         (bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_short (err_short),
        .o_err_long  (err_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write must match the head of the scoreboard, including whether done coincides.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {22'd0, bus.wr_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", {22'd0, bus.wr_addr}, {22'd0, e.addr});
                check("wr_data", {8'd0, bus.wr_data}, {8'd0, e.data});
                check("done_with_write", {31'd0, done}, {31'd0, e.dn});
            end
        end
    end

    task automatic start_line();
        line_req = 1'b1;
        @(posedge clk); #1;
        line_req = 1'b0;
    endtask

    task automatic send_beat(input logic [23:0] d, input bit last, input bit req);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        line_req    = req;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("beat_accepted", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        line_req    = 1'b0;
    endtask

    task automatic wait_done(input bit exp_s, input bit exp_l);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("err_short", {31'd0, err_short}, {31'd0, exp_s});
        check("err_long", {31'd0, err_long}, {31'd0, exp_l});
        check("busy_at_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("all_writes_seen", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // One line of last_idx+1 beats; data = base + beat index.
    task automatic run_line(input int last_idx, input bit gaps, input logic [23:0] base, input int req_at);
        start_line();
        for (int i = 0; i <= last_idx; i++) begin
            logic [23:0] d;
            d = base + 24'(i);
            if (i < int'(H)) begin
                sb.push_back('{addr: 10'(i), data: d,
                               dn: (i == last_idx) && ((i == int'(H) - 1) || !PAD)});
            end
            send_beat(d, i == last_idx, i == req_at);
            if (gaps && i != last_idx) begin
                @(posedge clk); #1;
            end
        end
        if (PAD && last_idx < int'(H) - 1) begin
            for (int a = last_idx + 1; a < int'(H); a++) begin
                sb.push_back('{addr: 10'(a), data: 24'h123456, dn: (a == int'(H) - 1)});
            end
        end
        wait_done(last_idx < int'(H) - 1, last_idx > int'(H) - 1);
    endtask

    initial begin
        rst         = 1'b1;
        line_req    = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err_short", {31'd0, err_short}, 32'd0);
        check("rst_err_long", {31'd0, err_long}, 32'd0);
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("rst_wr_addr", {22'd0, bus.wr_addr}, 32'd0);
        check("rst_wr_data", {8'd0, bus.wr_data}, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        line_req = 1'b0;
        @(negedge clk);
        check("req_in_rst_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        run_line(7, 1'b0, 24'h000001, -1);
        run_line(7, 1'b1, 24'h000100, 3);
        run_line(4, 1'b0, 24'h000200, -1);
        run_line(10, 1'b0, 24'h000300, -1);

        // Reset on the 4th beat: only beats 0..2 are written.
        start_line();
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{addr: 10'(i), data: 24'h000500 + 24'(i), dn: 1'b0});
            send_beat(24'h000500 + 24'(i), 1'b0, 1'b0);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = 24'h000503;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("midrst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("midrst_sb_empty", sb.size(), 32'd0);
        @(posedge clk); #1;

        run_line(7, 1'b0, 24'h000400, -1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected completion");
        $fatal(1);
    end
endmodule

// File: doc/line_fill_writer.md
Name: line_fill_writer

Overview:
- Write-side controller for the 24-bit, 1024-entry line buffer.
- On a per-line request, accepts one line of RGB888 pixels from an upstream valid/ready stream and issues registered write strobes (address, data, enable) into the buffer's write port.
- The display scan-out side then reads the line in the next line period.
- Detects short and long source lines, drains excess pixels, and reports completion and errors to the line sequencer.

Parameters:
- H_ACTIVE, 800, pixels per line; legal range 1..1024.
- PAD_COLOR, 24'h000000, fill value for missing pixels (used only with the optional feature).

Ports:
- clk  in  1  single clock; the write port of the line buffer runs on it.
- rst  in  1  synchronous, active-high reset.
- line_req  in  1  one-cycle pulse: start filling a new line. Honoured only in IDLE.
- s_valid  in  1  upstream pixel valid.
- s_data  in  24  upstream pixel, RGB888.
- s_last  in  1  marks the last pixel of a source line; qualified by s_valid.
- s_ready  out  1  pixel accepted when s_valid && s_ready.
- wr_addr  out  10  line buffer write address.
- wr_data  out  24  line buffer write data.
- wr_en  out  1  line buffer write enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the line is complete.
- err_short  out  1  sticky until next line_req: s_last seen before H_ACTIVE pixels.
- err_long  out  1  sticky until next line_req: no s_last on pixel H_ACTIVE.

Behaviour:
- Reset values: state=IDLE. s_ready, wr_en, busy, done, err_short and err_long are 0. wr_addr=0, wr_data=0. Pixel counter cnt=0.
- Reset mid-line aborts immediately. No further writes. Buffer contents are left as-is.

IDLE:
- s_ready=0.
- On line_req: cnt<=0, both error flags cleared, go to FILL next cycle.

FILL:
- s_ready=1.
- On each accepted beat, next cycle: wr_en=1, wr_addr=cnt, wr_data=s_data, and cnt<=cnt+1.
- Write latency is exactly 1 cycle from acceptance.
- wr_en is 0 on any cycle following a non-accepting cycle.
- Beat with cnt==H_ACTIVE-1 and s_last=1: go to DONE.
- Beat with cnt==H_ACTIVE-1 and s_last=0: set err_long, go to DRAIN.
- Beat with cnt<H_ACTIVE-1 and s_last=1: set err_short. Go to PAD if the feature is enabled, else DONE.

DRAIN:
- s_ready=1. Accepted beats are discarded (wr_en=0).
- On an accepted beat with s_last=1: go to DONE.

PAD (feature only):
- s_ready=0.
- Each cycle: wr_en=1, wr_addr=cnt, wr_data=PAD_COLOR, cnt<=cnt+1.
- After the write with cnt==H_ACTIVE-1 is issued: go to DONE.

DONE:
- done=1 for exactly one cycle. s_ready=0. Then IDLE.

General rules:
- busy=1 in FILL, DRAIN, PAD and DONE.
- line_req while busy is ignored. No queueing, no error flag.
- cnt is 10 bits and never exceeds H_ACTIVE-1 at a write. wr_addr never wraps.
- s_last on the same beat as cnt==H_ACTIVE-1 is the normal exact-length case. Neither error flag is set.
- H_ACTIVE=1: the first beat is also the last address.
- The final pixel write (wr_en on the registered cycle) coincides with the DONE cycle. done is therefore asserted in the same cycle as the last wr_en.
- Consumers may start reading the line the cycle after done.

Optional Feature:
- Macro: LINE_FILL_PAD_EN.
- Defined: a short line enters PAD and writes PAD_COLOR to the remaining addresses cnt..H_ACTIVE-1 at one per cycle, then DONE. All H_ACTIVE entries are always written per line.
- Undefined: the PAD state does not exist. A short line goes straight to DONE. Unwritten entries keep their previous-line contents. err_short still flags the condition.

Test Plan:
- Reset state: rst held 3 cycles -> all outputs 0, s_ready=0. line_req while rst=1 is ignored.
- Exact line, H_ACTIVE=8, continuous s_valid, data 0x000001..0x000008, s_last on 8th beat:
  - wr_en for 8 consecutive cycles, addresses 0..7, each 1 cycle after its acceptance.
  - done pulses with the addr-7 write.
  - err_short=err_long=0.
- Backpressure/gaps, H_ACTIVE=8: s_valid toggles 1,0,1,0… -> wr_en follows with 1-cycle lag, addresses contiguous 0..7, no duplicate or skipped writes.
- Short line, H_ACTIVE=8, s_last on 5th beat:
  - With LINE_FILL_PAD_EN, PAD_COLOR=24'h123456: addresses 5..7 written 0x123456 on 3 consecutive cycles, then done, err_short=1.
  - Without the macro: done after addr 4, no writes to 5..7, err_short=1.
- Long line, H_ACTIVE=8, 11 beats with s_last on beat 11 -> writes only to addresses 0..7, err_long=1, beats 9–11 consumed with s_ready=1, done after beat 11.
- Mid-line events:
  - line_req pulsed during FILL -> ignored, line completes normally.
  - rst asserted at beat 4 -> next cycle IDLE, wr_en=0, s_ready=0.
  - New line_req after rst -> writes restart at addr 0.
